// File: rtl/fifo_param.sv
// Parameterised circular-buffer FIFO with synchronous clear and asynchronous active-low reset.
// Optional macro FIFO_PARAM_PIPELINE_EN lets a full FIFO accept an enqueue alongside a dequeue.
module fifo_param #(
    parameter int WIDTH = 384,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       in_enq__ENA,
    input  logic [WIDTH-1:0]           in_enq_v,
    output logic                       in_enq__RDY,
    input  logic                       out_deq__ENA,
    output logic                       out_deq__RDY,
    output logic [WIDTH-1:0]           out_first,
    output logic                       out_first__RDY,
    input  logic                       clear__ENA,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             not_empty;
    logic             enq_fire;
    logic             deq_fire;

    // Handshake: a method fires on a rising edge only when its __ENA and __RDY
    // are both high in that cycle; an __ENA seen with __RDY low has no effect.
    assign not_empty = (count != '0);

`ifdef FIFO_PARAM_PIPELINE_EN
    assign in_enq__RDY = (count != FULL_CNT) || out_deq__ENA;
`else
    assign in_enq__RDY = (count != FULL_CNT);
`endif

    assign out_deq__RDY   = not_empty;
    assign out_first__RDY = not_empty;
    assign out_first      = not_empty ? mem[head] : '0;

    assign enq_fire = in_enq__ENA && in_enq__RDY;
    assign deq_fire = out_deq__ENA && out_deq__RDY;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear__ENA) begin
            // Flush only the pointers; stored words stay as they were.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                mem[tail] <= in_enq_v;
                tail      <= tail + 1'b1;
            end
            if (deq_fire) begin
                head <= head + 1'b1;
            end
            if (enq_fire && !deq_fire) begin
                count <= count + 1'b1;
            end else if (deq_fire && !enq_fire) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed vector table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_fifo_param;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
`ifdef FIFO_PARAM_PIPELINE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic          CLK;
    logic          nRST;
    logic          in_enq__ENA;
    logic [W-1:0]  in_enq_v;
    logic          in_enq__RDY;
    logic          out_deq__ENA;
    logic          out_deq__RDY;
    logic [W-1:0]  out_first;
    logic          out_first__RDY;
    logic          clear__ENA;
    logic [CW-1:0] count;

    fifo_param #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .in_enq__ENA    (in_enq__ENA),
        .in_enq_v       (in_enq_v),
        .in_enq__RDY    (in_enq__RDY),
        .out_deq__ENA   (out_deq__ENA),
        .out_deq__RDY   (out_deq__RDY),
        .out_first      (out_first),
        .out_first__RDY (out_first__RDY),
        .clear__ENA     (clear__ENA),
        .count          (count)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         enq;
        logic [W-1:0] data;
        logic         deq;
        logic         clr;
        int           exp_count;
        logic [W-1:0] exp_first;
    } vec_t;

    vec_t vecs[16];
    int   n_vecs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the reference queue for the inputs now applied.
    task automatic check_model(input logic deq_now);
        logic [W-1:0] exp_first;
        logic         exp_enq_rdy;
        exp_first   = (exp_q.size() != 0) ? exp_q[0] : '0;
        exp_enq_rdy = (exp_q.size() != D) || (PIPE == 1 && deq_now);
        check("model_count", 64'(count), 64'(exp_q.size()));
        check("model_first", 64'(out_first), 64'(exp_first));
        check("model_first_rdy", 64'(out_first__RDY), 64'(exp_q.size() != 0));
        check("model_deq_rdy", 64'(out_deq__RDY), 64'(exp_q.size() != 0));
        check("model_enq_rdy", 64'(in_enq__RDY), 64'(exp_enq_rdy));
    endtask

    // driver: apply one cycle of requests, check, clock it, update the model
    task automatic drive_cycle(input logic enq, input logic [W-1:0] data,
                               input logic deq, input logic clr);
        bit enq_ok, deq_ok;
        @(negedge CLK);
        in_enq__ENA  = enq;
        in_enq_v     = data;
        out_deq__ENA = deq;
        clear__ENA   = clr;
        #1;
        check_model(deq);
        enq_ok = enq && ((exp_q.size() != D) || (PIPE == 1 && deq));
        deq_ok = deq && (exp_q.size() != 0);
        @(posedge CLK);
        if (clr) begin
            exp_q.delete();
        end else begin
            if (deq_ok) void'(exp_q.pop_front());
            if (enq_ok) exp_q.push_back(data);
        end
        #1;
        in_enq__ENA  = 1'b0;
        out_deq__ENA = 1'b0;
        clear__ENA   = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(input logic enq, input logic [W-1:0] data, input logic deq,
                                input logic clr, input int c, input logic [W-1:0] f);
        vec_t v;
        v.enq = enq; v.data = data; v.deq = deq; v.clr = clr;
        v.exp_count = c; v.exp_first = f;
        return v;
    endfunction

    initial begin
        logic [W-1:0] lastv;
        logic [W-1:0] got;
        nRST = 1'b0;
        in_enq__ENA = 1'b0; in_enq_v = '0; out_deq__ENA = 1'b0; clear__ENA = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_enq_rdy", 64'(in_enq__RDY), 64'd1);
        check("rst_deq_rdy", 64'(out_deq__RDY), 64'd0);
        check("rst_first_rdy", 64'(out_first__RDY), 64'd0);
        check("rst_first", 64'(out_first), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Fill, full-FIFO enq+deq, simultaneous enq/deq, drain, deq on empty, clear priority.
        n_vecs = 0;
        vecs[n_vecs++] = mk(1, 16'h0001, 0, 0, 1, 16'h0001);
        vecs[n_vecs++] = mk(1, 16'h0002, 0, 0, 2, 16'h0001);
        vecs[n_vecs++] = mk(1, 16'h0003, 0, 0, 3, 16'h0001);
        vecs[n_vecs++] = mk(1, 16'h0004, 0, 0, 4, 16'h0001);
        vecs[n_vecs++] = mk(1, 16'h0005, 1, 0, 3 + PIPE, 16'h0002);
        vecs[n_vecs++] = mk(0, 16'h0000, 1, 0, 2 + PIPE, 16'h0003);
        vecs[n_vecs++] = mk(1, 16'h000C, 1, 0, 2 + PIPE, 16'h0004);
        vecs[n_vecs++] = mk(0, 16'h0000, 1, 0, 1 + PIPE, (PIPE == 1) ? 16'h0005 : 16'h000C);
        vecs[n_vecs++] = mk(0, 16'h0000, 1, 0, PIPE, (PIPE == 1) ? 16'h000C : 16'h0000);
        vecs[n_vecs++] = mk(0, 16'h0000, 1, 0, 0, 16'h0000);
        vecs[n_vecs++] = mk(1, 16'h0011, 0, 0, 1, 16'h0011);
        vecs[n_vecs++] = mk(1, 16'h0012, 0, 0, 2, 16'h0011);
        vecs[n_vecs++] = mk(1, 16'h0013, 0, 0, 3, 16'h0011);
        vecs[n_vecs++] = mk(1, 16'h0014, 0, 1, 0, 16'h0000);
        vecs[n_vecs++] = mk(1, 16'h0015, 0, 0, 1, 16'h0015);
        vecs[n_vecs++] = mk(0, 16'h0000, 1, 0, 0, 16'h0000);

        for (int i = 0; i < n_vecs; i++) begin
            drive_cycle(vecs[i].enq, vecs[i].data, vecs[i].deq, vecs[i].clr);
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d_first", i), 64'(out_first), 64'(vecs[i].exp_first));
            check($sformatf("vec%0d_first_rdy", i), 64'(out_first__RDY), 64'(vecs[i].exp_count != 0));
            if (i == 3) check("full_enq_rdy", 64'(in_enq__RDY), 64'd0);
        end

        // Drain across the pointer wrap: values must leave in order 1..6.
        drive_cycle(1, 16'h0001, 0, 0);
        drive_cycle(0, '0, 1, 0);
        drive_cycle(1, 16'h0002, 0, 0);
        drive_cycle(0, '0, 1, 0);
        for (int v = 3; v <= 6; v++) drive_cycle(1, W'(v), 0, 0);
        for (int v = 3; v <= 6; v++) begin
            got = out_first;
            check($sformatf("wrap_order%0d", v), 64'(got), 64'(v));
            drive_cycle(0, '0, 1, 0);
        end
        check("wrap_count", 64'(count), 64'd0);

        // Full enq+deq under the pipelined build: the new word becomes the tail entry.
        if (PIPE == 1) begin
            for (int v = 1; v <= 4; v++) drive_cycle(1, W'(16'h0020 + v), 0, 0);
            drive_cycle(1, 16'h00AB, 1, 0);
            check("pipe_full_count", 64'(count), 64'd4);
            for (int v = 0; v < 4; v++) begin
                lastv = out_first;
                drive_cycle(0, '0, 1, 0);
            end
            check("pipe_last_entry", 64'(lastv), 64'h00AB);
        end

        // Asynchronous reset between edges with two entries held.
        drive_cycle(1, 16'h0031, 0, 0);
        drive_cycle(1, 16'h0032, 0, 0);
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        exp_q.delete();
        check("arst_count", 64'(count), 64'd0);
        check("arst_first", 64'(out_first), 64'd0);
        check("arst_enq_rdy", 64'(in_enq__RDY), 64'd1);
        check("arst_deq_rdy", 64'(out_deq__RDY), 64'd0);
        // First enqueue is accepted on the first rising edge after release.
        @(negedge CLK);
        nRST = 1'b1;
        in_enq__ENA = 1'b1;
        in_enq_v = 16'h0041;
        @(posedge CLK);
        exp_q.push_back(16'h0041);
        #1;
        in_enq__ENA = 1'b0;
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_first", 64'(out_first), 64'h0041);

        // Randomized traffic against the reference queue.
        for (int n = 0; n < 400; n++) begin
            drive_cycle(1'($urandom_range(0, 1)), W'($urandom),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
        end
        drive_cycle(0, '0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
